riscv_core: RTL and testbench

- Minimal multi-cycle RV32I-subset processor. One unified word-array memory holds both instructions and data.
- Every instruction takes exactly two clock cycles: FETCH, then EXECUTE.
- Top-level compute block used in standalone CPU simulation. Benches preload memory and inspect state hierarchically.

---
 rtl/riscv_core.sv | 158 +++++++++++++++
 tb/tb_riscv_core.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_core.sv
// Two-cycle RV32I-subset core (FETCH/EXECUTE) over one unified word memory; RISCV_CORE_HALT_EN adds ECALL/EBREAK halt.
// Latency: 2 cycles per instruction; register/memory/pc updates land on the EXECUTE edge.
// Backpressure: none; the core free-runs from reset release.
module riscv_core #(
   parameter int          MEM_DEPTH = 256,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic [31:0] alu_result
`ifdef RISCV_CORE_HALT_EN
   ,
   output logic        halted
`endif
);
   localparam int AW = $clog2(MEM_DEPTH);

   typedef enum logic {FETCH, EXECUTE} state_t;
   state_t state, state_nxt;

   logic [31:0] registers [0:31];
   logic [31:0] memory    [0:MEM_DEPTH-1];

   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm_i, imm_s, imm_b, imm_j;
   logic [31:0] rs1_val, rs2_val, alu_out, wb_dat, pc_nxt;
   logic        wb_en, mem_we, halt_req, halt_active;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   assign rs1_val = (rs1 == 5'd0) ? 32'h0 : registers[rs1];
   assign rs2_val = (rs2 == 5'd0) ? 32'h0 : registers[rs2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!halt_active) begin
         case (state)
            FETCH:   state_nxt = EXECUTE;
            EXECUTE: state_nxt = FETCH;
            default: state_nxt = FETCH;
         endcase
      end
   end

   always_comb begin
      alu_out  = 32'h0;
      wb_dat   = 32'h0;
      wb_en    = 1'b0;
      mem_we   = 1'b0;
      halt_req = 1'b0;
      pc_nxt   = pc + 32'd4;
      case (opcode)
         7'b0110011: begin
            wb_en = 1'b1;
            case ({funct7, funct3})
               10'b0000000_000: alu_out = rs1_val + rs2_val;
               10'b0100000_000: alu_out = rs1_val - rs2_val;
               10'b0000000_111: alu_out = rs1_val & rs2_val;
               10'b0000000_110: alu_out = rs1_val | rs2_val;
               10'b0000000_100: alu_out = rs1_val ^ rs2_val;
               10'b0000000_001: alu_out = rs1_val << rs2_val[4:0];
               10'b0000000_101: alu_out = rs1_val >> rs2_val[4:0];
               10'b0000000_010: alu_out = {31'h0, $signed(rs1_val) < $signed(rs2_val)};
               default:         wb_en   = 1'b0;
            endcase
            wb_dat = alu_out;
         end
         7'b0010011: begin
            wb_en = 1'b1;
            case (funct3)
               3'b000:  alu_out = rs1_val + imm_i;
               3'b111:  alu_out = rs1_val & imm_i;
               3'b110:  alu_out = rs1_val | imm_i;
               3'b100:  alu_out = rs1_val ^ imm_i;
               3'b010:  alu_out = {31'h0, $signed(rs1_val) < $signed(imm_i)};
               default: wb_en   = 1'b0;
            endcase
            wb_dat = alu_out;
         end
         7'b0000011: if (funct3 == 3'b010) begin
            alu_out = rs1_val + imm_i;
            wb_dat  = memory[alu_out[AW-1:0]];
            wb_en   = 1'b1;
         end
         7'b0100011: if (funct3 == 3'b010) begin
            alu_out = rs1_val + imm_s;
            mem_we  = 1'b1;
         end
         7'b1100011: if (funct3 == 3'b000 || funct3 == 3'b001) begin
            alu_out = rs1_val - rs2_val;
            // funct3[0] selects BNE, so taken when equality differs from it
            if ((rs1_val == rs2_val) != funct3[0]) pc_nxt = pc + imm_b;
         end
         7'b1101111: begin
            alu_out = pc + 32'd4;
            wb_dat  = alu_out;
            wb_en   = 1'b1;
            pc_nxt  = pc + imm_j;
         end
`ifdef RISCV_CORE_HALT_EN
         7'b1110011: if (instr == 32'h00100073 || instr == 32'h00000073) begin
            halt_req = 1'b1;
            pc_nxt   = pc;
         end
`endif
         default: ;
      endcase
   end

`ifdef RISCV_CORE_HALT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                         halted <= 1'b0;
      else if (state == EXECUTE && halt_req) halted <= 1'b1;
   end
   assign halt_active = halted;
`else
   assign halt_active = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc         <= RESET_PC;
         instr      <= 32'h0;
         alu_result <= 32'h0;
         for (int i = 0; i < 32; i++) registers[i] <= 32'h0;
      end else if (state == FETCH) begin
         instr <= memory[pc[AW+1:2]];
      end else if (!halt_active) begin
         pc         <= pc_nxt;
         alu_result <= alu_out;
         if (wb_en && rd != 5'd0) registers[rd] <= wb_dat;
      end
   end

   // Memory contents deliberately survive reset; state is forced to FETCH while reset is low.
   always_ff @(posedge clk) begin
      if (state == EXECUTE && mem_we && !halt_active) memory[alu_out[AW-1:0]] <= rs2_val;
   end

endmodule

// File: tb/tb_riscv_core.sv
// Directed bench for riscv_core: program runs with a queue scoreboard of expected architectural state.
module tb_riscv_core;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc, instr, alu_result;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      int          kind;   // 0 pc, 1 instr, 2 alu_result, 3 register, 4 memory
      int          idx;
      logic [31:0] exp;
   } exp_t;
   exp_t sb[$];

   riscv_core #(.MEM_DEPTH(256), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .pc(pc), .instr(instr), .alu_result(alu_result)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic push(input string tag, input int kind, input int idx, input logic [31:0] exp);
      exp_t e;
      e.tag = tag; e.kind = kind; e.idx = idx; e.exp = exp;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] observe(input int kind, input int idx);
      case (kind)
         0:       return pc;
         1:       return instr;
         2:       return alu_result;
         3:       return dut.registers[idx];
         default: return dut.memory[idx];
      endcase
   endfunction

   task automatic drain();
      exp_t e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.kind, e.idx);
         checks++;
         assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic run_instr();
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic enter_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #1 reset = 1'b0;
      for (int i = 0; i < 256; i++) dut.memory[i] = 32'h0;
      dut.memory[0] = 32'h00500293;   // addi x5,x0,5
      dut.memory[1] = 32'h00600313;   // addi x6,x0,6
      dut.memory[2] = 32'h006283b3;   // add  x7,x5,x6
      dut.memory[3] = 32'h0072a023;   // sw   x7,0(x5)
      dut.memory[4] = 32'h0002a403;   // lw   x8,0(x5)
      dut.memory[7] = 32'h00700013;   // addi x0,x0,7
      repeat (2) @(negedge clk);

      push("rst_pc", 0, 0, 32'h0);
      push("rst_instr", 1, 0, 32'h0);
      push("rst_alu", 2, 0, 32'h0);
      for (int r = 1; r < 32; r++) push($sformatf("rst_x%0d", r), 3, r, 32'h0);
      push("rst_mem0_kept", 4, 0, 32'h00500293);
      drain();
      release_reset();

      push("addi_x5", 3, 5, 32'h5);   push("addi_alu", 2, 0, 32'h5); push("pc_1", 0, 0, 32'h4);
      run_instr(); drain();
      push("addi_x6", 3, 6, 32'h6);   push("pc_2", 0, 0, 32'h8);
      run_instr(); drain();
      push("add_x7", 3, 7, 32'hB);    push("add_alu", 2, 0, 32'hB);  push("pc_3", 0, 0, 32'hC);
      run_instr(); drain();
      push("sw_mem5", 4, 5, 32'hB);   push("sw_alu", 2, 0, 32'h5);   push("pc_4", 0, 0, 32'h10);
      run_instr(); drain();
      push("lw_x8", 3, 8, 32'hB);     push("lw_alu", 2, 0, 32'h5);   push("pc_5", 0, 0, 32'h14);
      run_instr(); drain();
      // memory[5] now holds 0xB, an unsupported opcode
      push("ill_alu", 2, 0, 32'h0);   push("ill_pc", 0, 0, 32'h18);
      push("ill_x8", 3, 8, 32'hB);    push("ill_mem5", 4, 5, 32'hB);
      run_instr(); drain();
      push("zero_alu", 2, 0, 32'h0);  push("zero_pc", 0, 0, 32'h1C);
      push("zero_x7", 3, 7, 32'hB);
      run_instr(); drain();
      push("x0_reg", 3, 0, 32'h0);    push("x0_alu", 2, 0, 32'h7);   push("x0_pc", 0, 0, 32'h20);
      run_instr(); drain();

      // Branch taken path, memory survives reset
      enter_reset();
      push("mem_survive", 4, 5, 32'hB); push("rst2_x5", 3, 5, 32'h0); push("rst2_pc", 0, 0, 32'h0);
      drain();
      dut.memory[1] = 32'h00500313;   // addi x6,x0,5
      dut.memory[2] = 32'h00628463;   // beq  x5,x6,+8
      dut.memory[3] = 32'h00629463;   // bne  x5,x6,+8
      dut.memory[4] = 32'h00100093;   // addi x1,x0,1
      dut.memory[5] = 32'hFEDFF0EF;   // jal  x1,-20
      release_reset();
      run_instr(); run_instr();
      push("beq_t_pc", 0, 0, 32'h10); push("beq_t_alu", 2, 0, 32'h0);
      run_instr(); drain();
      push("beq_t_instr", 1, 0, 32'h00100093); push("beq_t_x1", 3, 1, 32'h1); push("beq_t_pc2", 0, 0, 32'h14);
      run_instr(); drain();
      push("jal_pc", 0, 0, 32'h0);    push("jal_x1", 3, 1, 32'h18);  push("jal_alu", 2, 0, 32'h18);
      run_instr(); drain();

      // Branch not taken, then BNE taken
      enter_reset();
      dut.memory[1] = 32'h00600313;
      release_reset();
      run_instr(); run_instr();
      push("beq_nt_pc", 0, 0, 32'hC); push("beq_nt_alu", 2, 0, 32'hFFFFFFFF);
      run_instr(); drain();
      push("bne_t_pc", 0, 0, 32'h14); push("bne_t_alu", 2, 0, 32'hFFFFFFFF);
      run_instr(); drain();
      push("jal2_pc", 0, 0, 32'h0);   push("jal2_x1", 3, 1, 32'h18);
      run_instr(); drain();

      // R-type / SLTI mix with negative operands
      enter_reset();
      dut.memory[0] = 32'hFFD00293;   // addi x5,x0,-3
      dut.memory[1] = 32'h00600313;   // addi x6,x0,6
      dut.memory[2] = 32'h406283B3;   // sub  x7,x5,x6
      dut.memory[3] = 32'h0062A433;   // slt  x8,x5,x6
      dut.memory[4] = 32'h0062D4B3;   // srl  x9,x5,x6
      dut.memory[5] = 32'h00631533;   // sll  x10,x6,x6
      dut.memory[6] = 32'h0062C5B3;   // xor  x11,x5,x6
      dut.memory[7] = 32'hFFE2A613;   // slti x12,x5,-2
      dut.memory[8] = 32'h00502A23;   // sw   x5,20(x0)
      dut.memory[20] = 32'hDEADBEEF;
      release_reset();
      push("neg_x5", 3, 5, 32'hFFFFFFFD);
      run_instr(); drain();
      run_instr();
      push("sub_x7", 3, 7, 32'hFFFFFFF7);  run_instr(); drain();
      push("slt_x8", 3, 8, 32'h1);         run_instr(); drain();
      push("srl_x9", 3, 9, 32'h03FFFFFF);  run_instr(); drain();
      push("sll_x10", 3, 10, 32'h180);     run_instr(); drain();
      push("xor_x11", 3, 11, 32'hFFFFFFFB); run_instr(); drain();
      push("slti_x12", 3, 12, 32'h1);      push("slti_pc", 0, 0, 32'h20);
      run_instr(); drain();

      // Asynchronous reset in the middle of the store's EXECUTE cycle
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      push("async_pc", 0, 0, 32'h0); push("async_instr", 1, 0, 32'h0); push("async_alu", 2, 0, 32'h0);
      drain();
      repeat (2) @(posedge clk);
      @(negedge clk);
      push("abort_sw_mem20", 4, 20, 32'hDEADBEEF); push("async_x5", 3, 5, 32'h0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
